// File: rtl/adc_spi_cfg_master.sv
// SPI configuration initiator for the two HSMC ADCs (channel A / channel B).
// Each accepted command sends one 24-bit frame, MSB first:
// {R/W, 2'b00, addr[12:0], data[7:0]}.
// SCLK idles low. SDIO changes after the falling edge, and the ADC samples it on the rising edge.
// Optional build macro ADC_SPI_READBACK_EN enables reads:
//   - SDIO is released for the last 8 bits and HOLD.
//   - The returned byte is captured into rd_data.
// With the macro undefined, every frame is a write.
module adc_spi_cfg_master #(
  parameter int unsigned CLK_DIV  = 8,  // SCLK half-period in clk cycles (2..255)
  parameter int unsigned CS_SETUP = 2,  // CS low to first SCLK low phase (1..15)
  parameter int unsigned CS_HOLD  = 2,  // last SCLK high phase to CS high (1..15)
  parameter int unsigned GAP      = 4   // minimum CS high time between frames (1..15)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [1:0]  cmd_target,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        ad_sclk,
  output logic        ad_sdio_out,
  output logic        ad_sdio_oe,
  input  logic        ad_sdio_in,
  output logic        ada_spi_cs,
  output logic        adb_spi_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_t;

  localparam logic [7:0] PhaseLast = 8'(CLK_DIV - 1);
  localparam logic [3:0] SetupLast = 4'(CS_SETUP - 1);
  localparam logic [3:0] HoldLast  = 4'(CS_HOLD - 1);
  localparam logic [3:0] GapLast   = 4'(GAP - 1);

  state_t      r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_sclk;
  logic        r_sdio;
  logic        r_cs_a;
  logic        r_cs_b;
  logic [7:0]  r_phase;
  logic [4:0]  r_bit;
  logic [3:0]  r_cnt;
  logic [22:0] r_frame;  // bits still to send after the one on ad_sdio_out
  logic        w_rw;
  logic [23:0] w_frame;

`ifdef ADC_SPI_READBACK_EN
  logic        r_is_read;
  logic        r_oe;
  logic        r_rd_valid;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_rd_shift;
  assign w_rw = cmd_rw;
`else
  logic w_unused;
  assign w_rw     = 1'b0;
  assign w_unused = ^{cmd_rw, ad_sdio_in};
`endif

  assign w_frame = {w_rw, 2'b00, cmd_addr, cmd_data};

  // Frame sequencer: accept, CS setup, 24-bit shift, CS hold, inter-frame gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdio  <= 1'b0;
      r_cs_a  <= 1'b1;
      r_cs_b  <= 1'b1;
      r_phase <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_frame <= '0;
`ifdef ADC_SPI_READBACK_EN
      r_is_read  <= 1'b0;
      r_oe       <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_shift <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef ADC_SPI_READBACK_EN
      r_rd_valid <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (cmd_valid && r_ready) begin
            if (cmd_target == 2'b00) begin
              // No ADC selected: complete the command without a frame
              r_done <= 1'b1;
            end else begin
              r_state <= StSetup;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_cs_a  <= ~cmd_target[0];
              r_cs_b  <= ~cmd_target[1];
              r_sdio  <= w_frame[23];
              r_frame <= w_frame[22:0];
              r_cnt   <= '0;
`ifdef ADC_SPI_READBACK_EN
              r_is_read <= cmd_rw;
`endif
            end
          end
        end
        StSetup: begin
          if (r_cnt == SetupLast) begin
            r_state <= StShift;
            r_phase <= '0;
            r_bit   <= 5'd23;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StShift: begin
          if (r_phase != PhaseLast) begin
            r_phase <= r_phase + 8'd1;
          end else begin
            r_phase <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // End of a high phase: falling edge, then next bit or HOLD
              r_sclk <= 1'b0;
`ifdef ADC_SPI_READBACK_EN
              if (r_bit < 5'd8) r_rd_shift <= {r_rd_shift[6:0], ad_sdio_in};
`endif
              if (r_bit == 5'd0) begin
                r_state <= StHold;
                r_cnt   <= '0;
              end else begin
                r_bit   <= r_bit - 5'd1;
                r_sdio  <= r_frame[22];
                r_frame <= {r_frame[21:0], 1'b0};
`ifdef ADC_SPI_READBACK_EN
                // Bit 8 just finished: hand SDIO to the ADC for the data byte
                if (r_bit == 5'd8 && r_is_read) r_oe <= 1'b0;
`endif
              end
            end
          end
        end
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_state <= StGap;
            r_cnt   <= '0;
            r_cs_a  <= 1'b1;
            r_cs_b  <= 1'b1;
            r_sdio  <= 1'b0;
            r_done  <= 1'b1;
`ifdef ADC_SPI_READBACK_EN
            r_oe <= 1'b1;
            if (r_is_read) begin
              r_rd_data  <= r_rd_shift;
              r_rd_valid <= 1'b1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ad_sclk     = r_sclk;
  assign ad_sdio_out = r_sdio;
  assign ada_spi_cs  = r_cs_a;
  assign adb_spi_cs  = r_cs_b;
`ifdef ADC_SPI_READBACK_EN
  assign ad_sdio_oe = r_oe;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
`else
  assign ad_sdio_oe = 1'b1;
  assign rd_data    = 8'h00;
  assign rd_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_cfg_master.sv
// Self-checking bench for adc_spi_cfg_master.
// A negedge monitor plays the ADC side:
//   - counts CS-low cycles and SCLK rises;
//   - shifts SDIO into a word on every rise;
//   - drives the readback byte onto ad_sdio_in.
// Tests compare the monitor's totals against frame lengths and words computed from the
// command fields.
module tb_adc_spi_cfg_master;

  localparam int unsigned CLK_DIV  = 8;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned GAP      = 4;
  localparam int FRAME_LOW = CS_SETUP + 48 * CLK_DIV + CS_HOLD;  // 388
  localparam int ACC_TO_ACC = 1 + FRAME_LOW + GAP;               // 393

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [1:0]  cmd_target = 2'b00;
  logic [12:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        ad_sclk, ad_sdio_out, ad_sdio_oe;
  logic        ad_sdio_in = 1'b0;
  logic        ada_spi_cs, adb_spi_cs, busy, done, rd_valid;
  logic [7:0]  rd_data;

  int vectors = 0;
  int miscompares = 0;
  int pcyc = 0;

  adc_spi_cfg_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .GAP     (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_target (cmd_target),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .ad_sclk    (ad_sclk),
    .ad_sdio_out(ad_sdio_out),
    .ad_sdio_oe (ad_sdio_oe),
    .ad_sdio_in (ad_sdio_in),
    .ada_spi_cs (ada_spi_cs),
    .adb_spi_cs (adb_spi_cs),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  // ADC-side monitor: cumulative activity counters plus the readback driver
  int m_rises = 0, m_frame_rises = 0, m_cs_a_low = 0, m_cs_b_low = 0, m_cs_diff = 0;
  int m_done = 0, m_rdv = 0, m_rdv_done = 0, m_oe_low = 0, m_oe_start_rises = 0;
  int m_sclk_outside = 0, m_falls = 0;
  logic m_oe_start_sclk = 1'b0;
  logic [23:0] m_cap = '0;
  logic [7:0] rb_byte = 8'h00;
  logic m_prev_any = 1'b0, m_prev_sclk = 1'b0, m_prev_oe = 1'b1;
  int fall_q[$];
  int rise_q[$];

  always @(negedge clk) begin : mon
    logic cs_any;
    cs_any = !(ada_spi_cs && adb_spi_cs);
    if (cs_any && !m_prev_any) begin
      m_falls++;
      fall_q.push_back(pcyc);
      m_frame_rises = 0;
    end
    if (!cs_any && m_prev_any) rise_q.push_back(pcyc);
    if (!ada_spi_cs) m_cs_a_low++;
    if (!adb_spi_cs) m_cs_b_low++;
    if (ada_spi_cs != adb_spi_cs) m_cs_diff++;
    if (ad_sclk && !m_prev_sclk && cs_any) begin
      m_rises++;
      m_frame_rises++;
      m_cap = {m_cap[22:0], ad_sdio_out};
    end
    if (ad_sclk && !cs_any) m_sclk_outside++;
    // After the 16th bit the ADC presents its byte MSB first, changing after each fall
    if (!ad_sclk && m_prev_sclk && m_frame_rises >= 16 && m_frame_rises < 24)
      ad_sdio_in = rb_byte[23 - m_frame_rises];
    if (!ad_sdio_oe) begin
      m_oe_low++;
      if (m_prev_oe) begin
        m_oe_start_rises = m_frame_rises;
        m_oe_start_sclk  = ad_sclk;
      end
    end
    if (done) m_done++;
    if (rd_valid) begin
      m_rdv++;
      if (done) m_rdv_done++;
    end
    m_prev_any  = cs_any;
    m_prev_sclk = ad_sclk;
    m_prev_oe   = ad_sdio_oe;
  end

  // Present a command and wait (bounded) for its accept edge
  task automatic do_cmd(input logic rw, input logic [1:0] tgt, input logic [12:0] addr,
                        input logic [7:0] data, input bit hold, output int acc_t,
                        output bit to);
    to = 1'b0;
    @(negedge clk);
    cmd_rw = rw; cmd_target = tgt; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) to = 1'b1;
    acc_t = pcyc + 1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until the block is idle and ready again
  task automatic wait_idle(output int rdy_t, output bit to);
    to = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2000 && !(cmd_ready && !busy); i++) @(negedge clk);
    if (!(cmd_ready && !busy)) to = 1'b1;
    rdy_t = pcyc;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if ({ada_spi_cs, adb_spi_cs, ad_sclk, ad_sdio_out, ad_sdio_oe} !== 5'b11001) begin
      miscompares++; $display("FAIL reset_lines: got %b want 11001",
        {ada_spi_cs, adb_spi_cs, ad_sclk, ad_sdio_out, ad_sdio_oe}); end
    vectors++; if ({cmd_ready, busy, done, rd_valid} !== 4'b1000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 1000",
        {cmd_ready, busy, done, rd_valid}); end
    vectors++; if (rd_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_default();
    int a0, b0, r0, d0, v0, acc, rdy;
    bit to1, to2;
    a0 = m_cs_a_low; b0 = m_cs_b_low; r0 = m_rises; d0 = m_done; v0 = m_rdv;
    do_cmd(1'b0, 2'b01, 13'h014, 8'hA5, 1'b0, acc, to1);
    vectors++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL wr_busy: got busy=%b ready=%b want 1 0", busy, cmd_ready); end
    wait_idle(rdy, to2);
    vectors++; if ({to1, to2} !== 2'b00) begin
      miscompares++; $display("FAIL wr_timeout: got %b want 00", {to1, to2}); end
    vectors++; if (m_cs_a_low - a0 != FRAME_LOW) begin
      miscompares++; $display("FAIL wr_cs_a_len: got %0d want %0d", m_cs_a_low - a0, FRAME_LOW); end
    vectors++; if (m_cs_b_low - b0 != 0) begin
      miscompares++; $display("FAIL wr_cs_b_len: got %0d want 0", m_cs_b_low - b0); end
    vectors++; if (m_rises - r0 != 24) begin
      miscompares++; $display("FAIL wr_rises: got %0d want 24", m_rises - r0); end
    vectors++; if (m_cap !== 24'h0014A5) begin
      miscompares++; $display("FAIL wr_word: got %h want 0014a5", m_cap); end
    vectors++; if (m_done - d0 != 1) begin
      miscompares++; $display("FAIL wr_done: got %0d want 1", m_done - d0); end
    vectors++; if (m_rdv - v0 != 0) begin
      miscompares++; $display("FAIL wr_rd_valid: got %0d want 0", m_rdv - v0); end
    // rdy is the first negedge with ready high; the next edge is the earliest new accept
    vectors++; if (rdy + 1 - acc != ACC_TO_ACC) begin
      miscompares++; $display("FAIL wr_ready_time: got %0d want %0d", rdy + 1 - acc, ACC_TO_ACC); end
  endtask

  task automatic test_broadcast();
    int a0, b0, c0, acc, rdy;
    bit to1, to2;
    a0 = m_cs_a_low; b0 = m_cs_b_low; c0 = m_cs_diff;
    do_cmd(1'b0, 2'b11, 13'h0FF, 8'h01, 1'b0, acc, to1);
    wait_idle(rdy, to2);
    vectors++; if ({to1, to2} !== 2'b00) begin
      miscompares++; $display("FAIL bc_timeout: got %b want 00", {to1, to2}); end
    vectors++; if (m_cs_a_low - a0 != FRAME_LOW || m_cs_b_low - b0 != FRAME_LOW) begin
      miscompares++; $display("FAIL bc_cs_len: got %0d/%0d want %0d", m_cs_a_low - a0,
        m_cs_b_low - b0, FRAME_LOW); end
    vectors++; if (m_cs_diff - c0 != 0) begin
      miscompares++; $display("FAIL bc_cs_equal: got %0d differing cycles want 0",
        m_cs_diff - c0); end
    vectors++; if (m_cap !== 24'h00FF01) begin
      miscompares++; $display("FAIL bc_word: got %h want 00ff01", m_cap); end
  endtask

  task automatic test_null_target();
    int f0, r0, acc;
    bit to1;
    f0 = m_falls; r0 = m_rises;
    do_cmd(1'b0, 2'b00, 13'h123, 8'h45, 1'b0, acc, to1);
    @(negedge clk);
    vectors++; if ({to1, done, cmd_ready, busy} !== 4'b0110) begin
      miscompares++; $display("FAIL null_done: got to/done/ready/busy=%b want 0110",
        {to1, done, cmd_ready, busy}); end
    @(negedge clk);
    vectors++; if ({done, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL null_pulse: got done/ready=%b want 01", {done, cmd_ready}); end
    repeat (5) @(negedge clk);
    vectors++; if (m_falls - f0 != 0 || m_rises - r0 != 0) begin
      miscompares++; $display("FAIL null_activity: got %0d cs falls %0d rises want 0 0",
        m_falls - f0, m_rises - r0); end
  endtask

  task automatic test_back_to_back();
    int f0, d0, acc1, acc2, rdy, i;
    bit to1, to2;
    logic [12:0] a2;
    logic [7:0] dd2;
    a2 = 13'($urandom); dd2 = 8'($urandom);
    f0 = m_falls; d0 = m_done;
    do_cmd(1'b0, 2'b10, 13'($urandom), 8'($urandom), 1'b1, acc1, to1);
    // cmd_valid stays high with the next command while the first frame runs
    cmd_target = 2'b01; cmd_addr = a2; cmd_data = dd2;
    @(negedge clk);
    for (i = 0; i < 2000 && !cmd_ready; i++) @(negedge clk);
    acc2 = pcyc + 1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle(rdy, to2);
    vectors++; if ({to1, to2, cmd_ready} !== 3'b001) begin
      miscompares++; $display("FAIL b2b_timeout: got %b want 001", {to1, to2, cmd_ready}); end
    vectors++; if (m_falls - f0 != 2 || m_done - d0 != 2) begin
      miscompares++; $display("FAIL b2b_frames: got %0d frames %0d dones want 2 2",
        m_falls - f0, m_done - d0); end
    vectors++; if (fall_q[$] - rise_q[rise_q.size() - 2] != GAP + 1) begin
      miscompares++; $display("FAIL b2b_gap: got %0d want %0d",
        fall_q[$] - rise_q[rise_q.size() - 2], GAP + 1); end
    vectors++; if (acc2 - acc1 != ACC_TO_ACC) begin
      miscompares++; $display("FAIL b2b_accept: got %0d want %0d", acc2 - acc1, ACC_TO_ACC); end
    vectors++; if (m_cap !== {3'b000, a2, dd2}) begin
      miscompares++; $display("FAIL b2b_word: got %h want %h", m_cap, {3'b000, a2, dd2}); end
  endtask

  task automatic test_reset_mid_frame();
    int r0, d0, a0, acc, rdy;
    bit to1, to2;
    logic [12:0] ad;
    logic [7:0] dt;
    r0 = m_rises; d0 = m_done;
    do_cmd(1'b0, 2'b01, 13'($urandom), 8'($urandom), 1'b0, acc, to1);
    for (int i = 0; i < 2000 && (m_rises - r0) < 10; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({ada_spi_cs, adb_spi_cs, ad_sclk, cmd_ready, busy, done} !== 6'b110100) begin
      miscompares++; $display("FAIL rst_mid_lines: got %b want 110100",
        {ada_spi_cs, adb_spi_cs, ad_sclk, cmd_ready, busy, done}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (m_done - d0 != 0 || m_rises - r0 != 10 || to1) begin
      miscompares++; $display("FAIL rst_mid_done: got %0d dones %0d rises want 0 10",
        m_done - d0, m_rises - r0); end
    ad = 13'($urandom); dt = 8'($urandom); a0 = m_cs_a_low; d0 = m_done;
    do_cmd(1'b0, 2'b01, ad, dt, 1'b0, acc, to1);
    wait_idle(rdy, to2);
    vectors++; if (m_cap !== {3'b000, ad, dt} || m_cs_a_low - a0 != FRAME_LOW ||
                   m_done - d0 != 1 || to1 || to2) begin
      miscompares++; $display("FAIL rst_mid_after: got word %h len %0d dones %0d want %h %0d 1",
        m_cap, m_cs_a_low - a0, m_done - d0, {3'b000, ad, dt}, FRAME_LOW); end
  endtask

  task automatic test_random_writes();
    int a0, b0, acc, rdy;
    bit to1, to2;
    logic [1:0] tg;
    logic [12:0] ad;
    logic [7:0] dt;
    for (int n = 0; n < 4; n++) begin
      tg = 2'($urandom_range(1, 3)); ad = 13'($urandom); dt = 8'($urandom);
      a0 = m_cs_a_low; b0 = m_cs_b_low;
      do_cmd(1'b0, tg, ad, dt, 1'b0, acc, to1);
      wait_idle(rdy, to2);
      vectors++; if (m_cap !== {3'b000, ad, dt} || to1 || to2) begin
        miscompares++; $display("FAIL rnd_word[%0d]: got %h want %h", n, m_cap,
          {3'b000, ad, dt}); end
      vectors++; if (m_cs_a_low - a0 != (tg[0] ? FRAME_LOW : 0) ||
                     m_cs_b_low - b0 != (tg[1] ? FRAME_LOW : 0)) begin
        miscompares++; $display("FAIL rnd_cs[%0d]: got %0d/%0d target %b", n,
          m_cs_a_low - a0, m_cs_b_low - b0, tg); end
    end
  endtask

  task automatic test_readback();
    int o0, v0, vd0, acc, rdy;
    bit to1, to2;
    logic [12:0] ad;
    logic [7:0] dt;
    for (int n = 0; n < 3; n++) begin
      ad = (n == 0) ? 13'h001 : 13'($urandom);
      rb_byte = (n == 0) ? 8'h3C : 8'($urandom);
      dt = 8'($urandom);
      o0 = m_oe_low; v0 = m_rdv; vd0 = m_rdv_done;
      do_cmd(1'b1, 2'b01, ad, dt, 1'b0, acc, to1);
      wait_idle(rdy, to2);
      vectors++; if ({to1, to2} !== 2'b00) begin
        miscompares++; $display("FAIL rb_timeout[%0d]: got %b want 00", n, {to1, to2}); end
`ifdef ADC_SPI_READBACK_EN
      vectors++; if (m_cap[23:8] !== {3'b100, ad}) begin
        miscompares++; $display("FAIL rb_instr[%0d]: got %h want %h", n, m_cap[23:8],
          {3'b100, ad}); end
      vectors++; if (m_oe_low - o0 != 16 * CLK_DIV + CS_HOLD || m_oe_start_rises != 16 ||
                     m_oe_start_sclk !== 1'b0) begin
        miscompares++; $display("FAIL rb_oe[%0d]: got %0d cycles from rise %0d sclk %b want %0d 16 0",
          n, m_oe_low - o0, m_oe_start_rises, m_oe_start_sclk, 16 * CLK_DIV + CS_HOLD); end
      vectors++; if (rd_data !== rb_byte) begin
        miscompares++; $display("FAIL rb_data[%0d]: got %h want %h", n, rd_data, rb_byte); end
      vectors++; if (m_rdv - v0 != 1 || m_rdv_done - vd0 != 1) begin
        miscompares++; $display("FAIL rb_valid[%0d]: got %0d pulses %0d with done want 1 1",
          n, m_rdv - v0, m_rdv_done - vd0); end
`else
      vectors++; if (m_cap !== {3'b000, ad, dt}) begin
        miscompares++; $display("FAIL rb_as_write[%0d]: got %h want %h", n, m_cap,
          {3'b000, ad, dt}); end
      vectors++; if (m_rdv - v0 != 0 || m_oe_low - o0 != 0 || rd_data !== 8'h00) begin
        miscompares++; $display("FAIL rb_disabled[%0d]: got %0d pulses %0d oe-low rd %h want 0 0 00",
          n, m_rdv - v0, m_oe_low - o0, rd_data); end
`endif
    end
  endtask

  task automatic test_sclk_confined();
    vectors++; if (m_sclk_outside != 0) begin
      miscompares++; $display("FAIL sclk_outside_cs: got %0d cycles want 0", m_sclk_outside); end
  endtask

  initial begin
    test_reset();
    test_write_default();
    test_broadcast();
    test_null_target();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_writes();
    test_readback();
    test_sclk_confined();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_spi_cfg_master.md
Name: adc_spi_cfg_master

Overview:
- Serial-port initiator that writes, and optionally reads, configuration registers in the two HSMC ADCs (channel A and channel B).
- Drives the shared SCLK/SDIO lines and per-ADC chip selects that the top level currently ties off.
- Commands arrive from a Nios PIO/control block over a valid/ready handshake.
- One 24-bit frame is sent per command: a 16-bit instruction followed by 8 data bits.

Parameters:
- CLK_DIV, 8: SCLK half-period in clk cycles; legal range 2..255.
- CS_SETUP, 2: clk cycles from CS low to the first SCLK rise window; legal range 1..15.
- CS_HOLD, 2: clk cycles from the last SCLK high phase to CS high; legal range 1..15.
- GAP, 4: minimum clk cycles CS stays high between frames; legal range 1..15.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: block can accept a command.
- cmd_rw, in, 1: 0 = write, 1 = read (read only honoured with the optional feature).
- cmd_target, in, 2: bit0 selects ADC A, bit1 selects ADC B.
- cmd_addr, in, 13: register address.
- cmd_data, in, 8: write data.
- ad_sclk, out, 1: serial clock, idles low.
- ad_sdio_out, out, 1: serial data driven to the ADCs.
- ad_sdio_oe, out, 1: 1 = FPGA drives SDIO.
- ad_sdio_in, in, 1: SDIO pad input.
- ada_spi_cs, out, 1: ADC A chip select, active low.
- adb_spi_cs, out, 1: ADC B chip select, active low.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse at the end of each command.
- rd_data, out, 8: captured read byte.
- rd_valid, out, 1: one-cycle pulse when rd_data updates.

Behaviour:
- Reset values: ad_sclk=0, ad_sdio_out=0, ad_sdio_oe=1, ada_spi_cs=1, adb_spi_cs=1, cmd_ready=1, busy=0, done=0, rd_valid=0, rd_data=0.
- Accept rule: a command is accepted on a clk edge where cmd_valid && cmd_ready. All cmd_* fields are latched on that edge; cmd_ready drops on the next cycle.
- Frame word, MSB first:
  - [23] R/W (1 = read).
  - [22:21] = 00, one byte.
  - [20:8] address.
  - [7:0] data (don't-care for reads).
- States:
  - IDLE: cmd_ready=1. On accept go to SETUP, unless cmd_target==00; then no frame is sent, done pulses the cycle after accept, and the block stays IDLE.
  - SETUP: selected CS lines low; bit23 on ad_sdio_out; ad_sclk=0; lasts CS_SETUP cycles.
  - SHIFT: 24 bits. Each bit is CLK_DIV cycles with ad_sclk=0 followed by CLK_DIV cycles with ad_sclk=1.
    - ad_sdio_out changes only on the first cycle of a low phase, i.e. after the falling edge.
    - The ADC samples on the rising edge.
    - bit23 is already stable from SETUP.
  - HOLD: ad_sclk=0, CS low, CS_HOLD cycles.
  - GAP: both CS high, ad_sdio_oe=1, GAP cycles. done pulses on the first GAP cycle; cmd_ready=1 again the cycle after GAP ends.
- Frame timing: CS low for exactly CS_SETUP + 48*CLK_DIV + CS_HOLD cycles (defaults: 388). Accept-to-next-ready is 1 + that + GAP (defaults: 393).
- cmd_target==11: both CS lines go low together, giving an identical broadcast write.
- busy is 1 in every state except IDLE.
- Counters:
  - Bit counter 5 bits, counting 23 down to 0.
  - Phase counter 8 bits; wraps to 0 at CLK_DIV-1 and toggles the SCLK phase.
  - No SCLK edge is ever generated outside SHIFT.
- cmd_valid asserted while busy is ignored and not queued; the source holds it until cmd_ready.
- reset_n low at any time, including mid-frame: immediately forces all outputs to reset values (CS high within the same cycle, asynchronously), discards the frame, goes to IDLE, and emits no done pulse.

Optional Feature:
ADC_SPI_READBACK_EN
- Defined:
  - cmd_rw=1 sends bit23=1.
  - After the 16th bit's high phase, ad_sdio_oe drops to 0 at the start of the next low phase and stays 0 through HOLD.
  - ad_sdio_in is sampled on the last clk cycle of each of the 8 remaining high phases, MSB first.
  - rd_data updates and rd_valid pulses together with done.
  - ad_sdio_oe returns to 1 in GAP.
- Undefined:
  - cmd_rw is ignored and every frame is a write (bit23=0).
  - ad_sdio_oe is constant 1; rd_data is constant 0; rd_valid is constant 0.
  - ad_sdio_in is unused.

Test Plan:
- Write with defaults: target=01, addr=0x014, data=0xA5.
  - Expect ada_spi_cs low for 388 cycles and adb_spi_cs high throughout.
  - Expect 24 SCLK rises.
  - Bits captured on rises = 0x0014A5.
  - One done pulse; cmd_ready back 393 cycles after accept.
- Broadcast: target=11, addr=0x0FF, data=0x01.
  - Both CS low and identical; captured word = 0x00FF01.
- Null target: target=00.
  - No CS or SCLK activity; done pulses 1 cycle after accept; cmd_ready stays 1.
- Back-to-back: cmd_valid held high across two commands.
  - Second CS falls exactly GAP+1 cycles after the first CS rises.
  - cmd_valid while busy causes no extra frame.
- Reset mid-frame: reset_n low after 10 SCLK rises.
  - CS high and SCLK low in the same cycle; no done pulse.
  - A subsequent write frames correctly.
- Readback (ADC_SPI_READBACK_EN): read addr=0x001, model drives 0x3C on SDIO.
  - ad_sdio_oe=0 exactly for bits 7..0 and HOLD.
  - rd_data=0x3C; rd_valid coincides with done.
  - Without the macro, the same stimulus yields captured bit23=0 and rd_valid never asserted.
